// File: rtl/layer3_result_read_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : layer3_result_read_scheduler                                  |
// | Purpose  : Walks every layer4 output position once layer3 has finished   |
// |            writing its frame, issues the KERNELxKERNEL window reads to    |
// |            the layer3 result SRAM (port B, one-cycle read latency) and    |
// |            tags each returned word for the layer4 convolution engine.     |
// | Options  : LAYER3_SCHED_PAD_EN - schedule with a one-pixel zero border;  |
// |            out-of-map taps occupy an issue slot without a memory read.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module layer3_result_read_scheduler #(
  parameter int MAP_WIDTH = 14,
  parameter int KERNEL    = 3,
  parameter int STRIDE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        layer3_save_enable,
  input  logic        layer4_ready,
  output logic [15:0] read_row_addr,
  output logic [15:0] read_col_addr,
  output logic        layer3_result_read_signal,
  output logic        tap_valid,
  output logic [3:0]  tap_index,
  output logic        tap_zero,
  output logic        tap_last,
  output logic [15:0] out_row,
  output logic [15:0] out_col,
  output logic        busy,
  output logic        frame_done,
  output logic        write_conflict
);

`ifdef LAYER3_SCHED_PAD_EN
  // A one-pixel border keeps the output map the same size as the input map.
  localparam int c_out_dim = MAP_WIDTH;
`else
  localparam int c_out_dim = (MAP_WIDTH - KERNEL) / STRIDE + 1;
`endif

  localparam logic [15:0] c_out_max = 16'(c_out_dim - 1);
  localparam logic [3:0]  c_k_max   = 4'(KERNEL - 1);
  localparam logic [3:0]  c_tap_max = 4'(KERNEL * KERNEL - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_scan  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] orow_q, orow_d;
  logic [15:0] ocol_q, ocol_d;
  logic [3:0]  ky_q, ky_d;
  logic [3:0]  kx_q, kx_d;

  logic        tap_valid_q, tap_valid_d;
  logic [3:0]  tap_index_q, tap_index_d;
  logic        tap_last_q, tap_last_d;
  logic [15:0] out_row_q, out_row_d;
  logic [15:0] out_col_q, out_col_d;
  logic        frame_done_q, frame_done_d;
  logic        write_conflict_q, write_conflict_d;

  logic        w_issue;
  logic        w_final;
  logic        w_tap_ok;
  logic [3:0]  w_tap_index;
  logic [15:0] w_row_pos;
  logic [15:0] w_col_pos;
  logic [15:0] w_row_addr;
  logic [15:0] w_col_addr;

  // An issue slot is consumed every SCAN cycle the consumer can take a tap.
  assign w_issue     = (state_q == c_st_scan) && layer4_ready;
  assign w_final     = (orow_q == c_out_max) && (ocol_q == c_out_max) &&
                       (ky_q == c_k_max) && (kx_q == c_k_max);
  assign w_tap_index = ky_q * 4'(KERNEL) + kx_q;

  // Map coordinate of the current tap (offset by one under padding).
  assign w_row_pos = orow_q * 16'(STRIDE) + 16'(ky_q);
  assign w_col_pos = ocol_q * 16'(STRIDE) + 16'(kx_q);

`ifdef LAYER3_SCHED_PAD_EN
  logic tap_zero_q, tap_zero_d;

  // Position 0 and MAP_WIDTH+1 lie on the zero border; shift back to 0-based.
  assign w_tap_ok   = (w_row_pos != 16'd0) && (w_row_pos <= 16'(MAP_WIDTH)) &&
                      (w_col_pos != 16'd0) && (w_col_pos <= 16'(MAP_WIDTH));
  assign w_row_addr = w_row_pos - 16'd1;
  assign w_col_addr = w_col_pos - 16'd1;
  assign tap_zero_d = w_issue ? !w_tap_ok : tap_zero_q;
  assign tap_zero   = tap_zero_q;

  // Padding flag travels with the tap through the read latency.
  always_ff @(posedge clk) begin
    if (rst) tap_zero_q <= 1'b0;
    else     tap_zero_q <= tap_zero_d;
  end
`else
  assign w_tap_ok   = 1'b1;
  assign w_row_addr = w_row_pos;
  assign w_col_addr = w_col_pos;
  assign tap_zero   = 1'b0;
`endif

  assign layer3_result_read_signal = w_issue && w_tap_ok;
  assign read_row_addr             = w_tap_ok ? w_row_addr : 16'd0;
  assign read_col_addr             = w_tap_ok ? w_col_addr : 16'd0;
  assign busy                      = (state_q != c_st_idle);

  assign tap_valid      = tap_valid_q;
  assign tap_index      = tap_index_q;
  assign tap_last       = tap_last_q;
  assign out_row        = out_row_q;
  assign out_col        = out_col_q;
  assign frame_done     = frame_done_q;
  assign write_conflict = write_conflict_q;

  // Sequencer: FSM, raster counters and the tag pipeline matching read latency.
  always_comb begin
    state_d          = state_q;
    orow_d           = orow_q;
    ocol_d           = ocol_q;
    ky_d             = ky_q;
    kx_d             = kx_q;
    tap_valid_d      = w_issue;
    tap_index_d      = tap_index_q;
    tap_last_d       = tap_last_q;
    out_row_d        = out_row_q;
    out_col_d        = out_col_q;
    frame_done_d     = w_issue && w_final;
    write_conflict_d = write_conflict_q || (layer3_save_enable && busy);

    if (w_issue) begin
      tap_index_d = w_tap_index;
      tap_last_d  = (w_tap_index == c_tap_max);
      out_row_d   = orow_q;
      out_col_d   = ocol_q;
    end

    case (state_q)
      c_st_idle: begin
        if (frame_start) begin
          state_d = c_st_scan;
          orow_d  = 16'd0;
          ocol_d  = 16'd0;
          ky_d    = 4'd0;
          kx_d    = 4'd0;
        end
      end
      c_st_scan: begin
        if (w_issue) begin
          // kx innermost, then ky, ocol, orow; all wrap to 0 after the last tap.
          if (kx_q == c_k_max) begin
            kx_d = 4'd0;
            if (ky_q == c_k_max) begin
              ky_d = 4'd0;
              if (ocol_q == c_out_max) begin
                ocol_d = 16'd0;
                orow_d = (orow_q == c_out_max) ? 16'd0 : orow_q + 16'd1;
              end else begin
                ocol_d = ocol_q + 16'd1;
              end
            end else begin
              ky_d = ky_q + 4'd1;
            end
          end else begin
            kx_d = kx_q + 4'd1;
          end
          if (w_final) state_d = c_st_drain;
        end
      end
      c_st_drain: state_d = c_st_idle;
      default:    state_d = c_st_idle;
    endcase
  end

  // State registers; reset also drops any tap still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= c_st_idle;
      orow_q           <= 16'd0;
      ocol_q           <= 16'd0;
      ky_q             <= 4'd0;
      kx_q             <= 4'd0;
      tap_valid_q      <= 1'b0;
      tap_index_q      <= 4'd0;
      tap_last_q       <= 1'b0;
      out_row_q        <= 16'd0;
      out_col_q        <= 16'd0;
      frame_done_q     <= 1'b0;
      write_conflict_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      orow_q           <= orow_d;
      ocol_q           <= ocol_d;
      ky_q             <= ky_d;
      kx_q             <= kx_d;
      tap_valid_q      <= tap_valid_d;
      tap_index_q      <= tap_index_d;
      tap_last_q       <= tap_last_d;
      out_row_q        <= out_row_d;
      out_col_q        <= out_col_d;
      frame_done_q     <= frame_done_d;
      write_conflict_q <= write_conflict_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer3_result_read_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_layer3_result_read_scheduler                               |
// | Purpose  : Scoreboard bench for layer3_result_read_scheduler; follows    |
// |            LAYER3_SCHED_PAD_EN the same way as the design.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_layer3_result_read_scheduler;

  localparam int MW = 14;
  localparam int K  = 3;
  localparam int S  = 1;
`ifdef LAYER3_SCHED_PAD_EN
  localparam int PAD = 1;
  localparam int OD  = MW;
`else
  localparam int PAD = 0;
  localparam int OD  = (MW - K) / S + 1;
`endif
  localparam int N = OD * OD * K * K;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        layer3_save_enable;
  logic        layer4_ready;
  logic [15:0] read_row_addr;
  logic [15:0] read_col_addr;
  logic        layer3_result_read_signal;
  logic        tap_valid;
  logic [3:0]  tap_index;
  logic        tap_zero;
  logic        tap_last;
  logic [15:0] out_row;
  logic [15:0] out_col;
  logic        busy;
  logic        frame_done;
  logic        write_conflict;

  layer3_result_read_scheduler #(.MAP_WIDTH(MW), .KERNEL(K), .STRIDE(S)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .frame_start               (frame_start),
    .layer3_save_enable        (layer3_save_enable),
    .layer4_ready              (layer4_ready),
    .read_row_addr             (read_row_addr),
    .read_col_addr             (read_col_addr),
    .layer3_result_read_signal (layer3_result_read_signal),
    .tap_valid                 (tap_valid),
    .tap_index                 (tap_index),
    .tap_zero                  (tap_zero),
    .tap_last                  (tap_last),
    .out_row                   (out_row),
    .out_col                   (out_col),
    .busy                      (busy),
    .frame_done                (frame_done),
    .write_conflict            (write_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int c;
    int idx;
    int orow;
    int ocol;
    bit last;
    bit zero;
  } tap_t;

  tap_t frame_taps[$];
  tap_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: every output position, window taps in ky-major order.
  function automatic void build_frame();
    tap_t t;
    frame_taps.delete();
    for (int orow = 0; orow < OD; orow++)
      for (int ocol = 0; ocol < OD; ocol++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            t.r    = orow * S + ky - PAD;
            t.c    = ocol * S + kx - PAD;
            t.idx  = ky * K + kx;
            t.orow = orow;
            t.ocol = ocol;
            t.last = (ky == K - 1) && (kx == K - 1);
            t.zero = (t.r < 0) || (t.r >= MW) || (t.c < 0) || (t.c >= MW);
            frame_taps.push_back(t);
          end
  endfunction

  task automatic push_frame();
    foreach (frame_taps[i]) exp_q.push_back(frame_taps[i]);
  endtask

  task automatic step(input bit r, input bit rdy, input bit fs, input bit we);
    @(posedge clk);
    #1;
    rst                = r;
    layer4_ready       = rdy;
    frame_start        = fs;
    layer3_save_enable = we;
  endtask

  // Monitor: each returned tap is popped from the scoreboard and compared,
  // including the read that must have been issued in the previous cycle.
  initial begin
    tap_t        e;
    logic        prev_rd;
    logic [15:0] prev_row;
    logic [15:0] prev_col;
    prev_rd  = 1'b0;
    prev_row = 16'd0;
    prev_col = 16'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rd = 1'b0;
      end else begin
        if (tap_valid) begin
          if (exp_q.size() == 0) begin
            chk("tap_unexpected", tap_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("tap_index", tap_index, e.idx);
            chk("out_row", out_row, e.orow);
            chk("out_col", out_col, e.ocol);
            chk("tap_last", tap_last, e.last);
            chk("tap_zero", tap_zero, e.zero);
            chk("read_en_prev", prev_rd, !e.zero);
            if (!e.zero) begin
              chk("read_row", prev_row, e.r);
              chk("read_col", prev_col, e.c);
            end
            chk("frame_done_tag", frame_done, exp_q.size() == 0);
          end
        end else begin
          if (frame_done) chk("frame_done_stray", frame_done, 0);
          if (prev_rd)    chk("tap_missing", tap_valid, 1);
        end
        if (frame_done) done_pulses++;
        prev_rd  = layer3_result_read_signal;
        prev_row = read_row_addr;
        prev_col = read_col_addr;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed frame, aborted random frame, full random frame.
  initial begin
    int exp_done;
    int issued;
    bit rdy;
    bit we;
    bit wc_exp;

    rst = 1'b1; frame_start = 1'b0; layer3_save_enable = 1'b0; layer4_ready = 1'b0;
    build_frame();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tap_valid", tap_valid, 0);
    chk("rst_read_en", layer3_result_read_signal, 0);
    chk("rst_read_row", read_row_addr, 0);
    chk("rst_read_col", read_col_addr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_conflict", write_conflict, 0);
    chk("rst_tap_index", tap_index, 0);
    chk("rst_tap_last", tap_last, 0);
    chk("rst_tap_zero", tap_zero, 0);

    // Frame A: ready low 20..24, ignored restart at 100, write at 50.
    done_pulses = 0;
    step(0, 1, 1, 0);
    push_frame();
    exp_done = N + 6;
    for (int c = 1; c <= exp_done + 1; c++) begin
      step(0, !(c >= 20 && c <= 24), c == 100, c == 50);
      @(negedge clk);
      if (c == 1 || c == 10) begin
        chk("early_read_en", layer3_result_read_signal, !frame_taps[c-1].zero);
        if (!frame_taps[c-1].zero) begin
          chk("early_read_row", read_row_addr, frame_taps[c-1].r);
          chk("early_read_col", read_col_addr, frame_taps[c-1].c);
        end
      end
      if (c >= 20 && c <= 24) chk("stall_no_read", layer3_result_read_signal, 0);
      if (c >= 21 && c <= 25) chk("stall_no_tap", tap_valid, 0);
      if (c == 51)            chk("conflict_set", write_conflict, 1);
      if (c == exp_done) begin
        chk("done_cycle", frame_done, 1);
        chk("busy_at_done", busy, 1);
      end
      if (c == exp_done + 1) chk("busy_fall", busy, 0);
    end
    chk("a_done_pulses", done_pulses, 1);
    chk("a_queue_empty", exp_q.size(), 0);
    chk("conflict_sticky", write_conflict, 1);

    step(1, 1, 0, 0);
    exp_q.delete();
    step(0, 1, 0, 0);
    @(negedge clk);
    chk("conflict_cleared", write_conflict, 0);

    // Frame B: random backpressure, reset at cycle 600 aborts the scan.
    step(0, 1, 1, 0);
    push_frame();
    for (int c = 1; c < 600; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      step(0, rdy, 0, c == 300);
    end
    step(1, 1, 0, 0);
    exp_q.delete();
    step(0, 1, 0, 0);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_tap_valid", tap_valid, 0);
    chk("abort_read_en", layer3_result_read_signal, 0);
    chk("abort_frame_done", frame_done, 0);
    chk("abort_read_row", read_row_addr, 0);
    chk("abort_read_col", read_col_addr, 0);
    chk("abort_conflict", write_conflict, 0);

    // Frame C: random backpressure and writes, run to completion.
    done_pulses = 0;
    wc_exp = 1'b0;
    issued = 0;
    exp_done = -1;
    rdy = 1'b1;
    step(0, 1, 1, 0);
    push_frame();
    for (int c = 1; c < 20000 && exp_done < 0; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 99) == 0);
      step(0, rdy, 0, we);
      if (we) wc_exp = 1'b1;
      @(negedge clk);
      if (rdy && issued == 0) begin
        chk("c_first_read_en", layer3_result_read_signal, !frame_taps[0].zero);
        if (!frame_taps[0].zero) begin
          chk("c_first_row", read_row_addr, frame_taps[0].r);
          chk("c_first_col", read_col_addr, frame_taps[0].c);
        end
      end
      if (rdy) issued++;
      if (issued == N) exp_done = c + 1;
    end
    if (exp_done < 0) begin
      chk("c_timeout", issued, N);
    end else begin
      step(0, 1, 0, 0);
      @(negedge clk);
      chk("c_done_cycle", frame_done, 1);
      chk("c_busy_at_done", busy, 1);
      step(0, 1, 0, 0);
      @(negedge clk);
      chk("c_busy_fall", busy, 0);
      chk("c_conflict", write_conflict, wc_exp);
    end
    chk("c_done_pulses", done_pulses, 1);
    chk("c_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
